// File: rtl/uart_fifo_controller.sv
// uart_fifo_controller: APB UART with programmable frame format (5-8 data bits,
// optional parity, 1/2 stop bits), separate RX/TX FIFOs, 3-point majority RX
// sampling, per-entry error flags, break detection and a level interrupt.
// Optional hardware flow control (uart_cts_n / uart_rts_n) is built only when
// the macro UART_FLOW_CTRL_EN is defined; the default build omits those ports.
module uart_fifo_controller #(
   parameter int          RX_FIFO_DEPTH = 64,
   parameter int          TX_FIFO_DEPTH = 64,
   parameter logic [15:0] DIV_RESET     = 16'd9,
   parameter logic [15:0] OVERRIDE_DIV  = 16'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq,
   input  logic [3:0]  apb_PADDR,
   input  logic        apb_PSEL,
   input  logic        apb_PENABLE,
   input  logic        apb_PWRITE,
   input  logic [31:0] apb_PWDATA,
   output logic        apb_PREADY,
   output logic [31:0] apb_PRDATA
`ifdef UART_FLOW_CTRL_EN
   ,
   input  logic        uart_cts_n,
   output logic        uart_rts_n
`endif
);

   localparam int RFB = $clog2(RX_FIFO_DEPTH);
   localparam int TFB = $clog2(TX_FIFO_DEPTH);

   typedef struct packed {
      logic       brk;
      logic       ferr;
      logic       perr;
      logic [7:0] data;
   } rx_entry_t;

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_st_t;
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;

   function automatic logic [7:0] sat8(input logic [15:0] v);
      return (v > 16'd255) ? 8'hFF : v[7:0];
   endfunction

   // configuration / interrupt registers
   logic [15:0] divisor;
   logic [1:0]  dbits;
   logic        par_en, par_odd, stop2;
   logic [3:0]  irq_en;
   logic [3:0]  sticky;      // {FERR, BRK, TXOVR, RXOVR}
   logic [3:0]  rx_thr, tx_thr;

   // FIFOs
   rx_entry_t   rx_mem [RX_FIFO_DEPTH];
   logic [7:0]  tx_mem [TX_FIFO_DEPTH];
   logic [RFB:0] rx_wp, rx_rp, rx_lvl;
   logic [TFB:0] tx_wp, tx_rp, tx_lvl;
   logic        rx_empty, rx_full, tx_empty, tx_full;
   logic [7:0]  rx_lvl8, tx_lvl8;
   rx_entry_t   rx_head, rx_ent;
   logic        rx_push, rx_pop, rx_do_push;
   logic        tx_wr, tx_pop, tx_do_push;

   // APB decode
   logic        acc, wr, rd, conf_wr_req, conf_wr;
   logic [1:0]  ra;
   rx_st_t      rx_st;
   tx_st_t      tx_st;
   logic        cts_ok;

   assign acc         = apb_PSEL & apb_PENABLE;
   assign ra          = apb_PADDR[3:2];
   assign wr          = acc & apb_PWRITE;
   assign rd          = acc & ~apb_PWRITE;
   assign conf_wr_req = wr & (ra == 2'd2);
   // a format change must not disturb a frame in flight, so CONF waits for TX to drain
   assign apb_PREADY  = ~(conf_wr_req & ~(tx_empty & (tx_st == T_IDLE)));
   assign conf_wr     = conf_wr_req & apb_PREADY;

   logic unused_bits;
   assign unused_bits = &{1'b0, apb_PADDR[1:0], apb_PWDATA[31:24]};

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[RFB] != rx_rp[RFB]) && (rx_wp[RFB-1:0] == rx_rp[RFB-1:0]);
   assign rx_lvl   = rx_wp - rx_rp;
   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[TFB] != tx_rp[TFB]) && (tx_wp[TFB-1:0] == tx_rp[TFB-1:0]);
   assign tx_lvl   = tx_wp - tx_rp;
   assign rx_lvl8  = sat8(16'(rx_lvl));
   assign tx_lvl8  = sat8(16'(tx_lvl));
   assign rx_head  = rx_mem[rx_rp[RFB-1:0]];

   assign rx_pop     = rd & (ra == 2'd0) & ~rx_empty;
   assign rx_do_push = rx_push & (~rx_full | rx_pop);
   assign tx_wr      = wr & (ra == 2'd1);
   assign tx_do_push = tx_wr & (~tx_full | tx_pop);

   // register read mux
   always_comb begin
      apb_PRDATA = 32'd0;
      case (ra)
         2'd0: apb_PRDATA = rx_empty ? 32'h8000_0000 : {21'd0, rx_head};
         2'd1: apb_PRDATA = {tx_full, tx_empty, 14'd0, rx_lvl8, tx_lvl8};
         2'd2: apb_PRDATA = {11'd0, stop2, par_odd, par_en, dbits, divisor};
         default: apb_PRDATA = {8'd0, tx_thr, rx_thr, 4'd0, sticky, 4'd0, irq_en};
      endcase
   end

   // RX FIFO storage
   always_ff @(posedge clk) begin
      if (rx_do_push) rx_mem[rx_wp[RFB-1:0]] <= rx_ent;
   end

   // TX FIFO storage
   always_ff @(posedge clk) begin
      if (tx_do_push) tx_mem[tx_wp[TFB-1:0]] <= apb_PWDATA[7:0];
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_wp <= '0; rx_rp <= '0; tx_wp <= '0; tx_rp <= '0;
      end else begin
         if (rx_do_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)     rx_rp <= rx_rp + 1'b1;
         if (tx_do_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)     tx_rp <= tx_rp + 1'b1;
      end
   end

   // configuration, enables, thresholds and sticky status
   logic [3:0] st_set, st_clr;
   assign st_set = {rx_push & rx_ent.ferr, rx_push & rx_ent.brk,
                    tx_wr & ~tx_do_push, rx_push & ~rx_do_push};
   assign st_clr = (wr & (ra == 2'd3)) ? apb_PWDATA[11:8] : 4'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         divisor <= DIV_RESET;
         dbits   <= 2'd3;
         par_en  <= 1'b0;
         par_odd <= 1'b0;
         stop2   <= 1'b0;
         irq_en  <= 4'd0;
         rx_thr  <= 4'd0;
         tx_thr  <= 4'd0;
         sticky  <= 4'd0;
      end else begin
         if (conf_wr) begin
            divisor <= (OVERRIDE_DIV != 16'd0) ? OVERRIDE_DIV : apb_PWDATA[15:0];
            dbits   <= apb_PWDATA[17:16];
            par_en  <= apb_PWDATA[18];
            par_odd <= apb_PWDATA[19];
            stop2   <= apb_PWDATA[20];
         end
         if (wr && ra == 2'd3) begin
            irq_en <= apb_PWDATA[3:0];
            rx_thr <= apb_PWDATA[19:16];
            tx_thr <= apb_PWDATA[23:20];
         end
         // a new event in the same cycle as a clear wins
         sticky <= (sticky & ~st_clr) | st_set;
      end
   end

   // interrupt: registered OR of enabled conditions
   logic [3:0] rx_thr_eff;
   logic       cond_rxne, cond_txlow;
   assign rx_thr_eff = (rx_thr == 4'd0) ? 4'd1 : rx_thr;
   assign cond_rxne  = rx_lvl8 >= {4'd0, rx_thr_eff};
   assign cond_txlow = tx_lvl8 <= {4'd0, tx_thr};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= |(irq_en & {sticky[2], sticky[0], cond_txlow, cond_rxne});
   end

   // RX input synchroniser plus previous value for edge detect
   logic rx_meta, rx_s, rx_prev;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1; rx_s <= 1'b1; rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx; rx_s <= rx_meta; rx_prev <= rx_s;
      end
   end

   // RX bit timing: rcnt counts cycles inside the current bit (0..divisor)
   logic [15:0] rcnt, half;
   logic [1:0]  rsmp;
   logic [2:0]  rbit;
   logic [7:0]  rdata;
   logic        rzero, rperr, rmaj, samp_win, samp_dec, r_end;
   assign half     = divisor >> 1;
   assign samp_win = (rcnt == half - 16'd1) || (rcnt == half) || (rcnt == half + 16'd1);
   assign samp_dec = (rcnt == half + 16'd1);
   assign r_end    = (rcnt == divisor);
   assign rmaj     = (rsmp[1] & rsmp[0]) | (rsmp[1] & rx_s) | (rsmp[0] & rx_s);

   // RX frame FSM; entry is staged in rx_ent and pushed the cycle after the stop sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_st   <= R_IDLE;
         rcnt    <= 16'd0;
         rsmp    <= 2'b11;
         rbit    <= 3'd0;
         rdata   <= 8'd0;
         rzero   <= 1'b1;
         rperr   <= 1'b0;
         rx_push <= 1'b0;
         rx_ent  <= '0;
      end else begin
         rx_push <= 1'b0;
         if (rx_st != R_IDLE && rx_st != R_BRK) begin
            rcnt <= r_end ? 16'd0 : rcnt + 16'd1;
            if (samp_win) rsmp <= {rsmp[0], rx_s};
         end
         case (rx_st)
            R_IDLE: if (rx_prev && !rx_s) begin
               rx_st <= R_START;
               rcnt  <= 16'd1;
               rbit  <= 3'd0;
               rdata <= 8'd0;
               rzero <= 1'b1;
               rperr <= 1'b0;
            end
            R_START: begin
               if (samp_dec && rmaj) rx_st <= R_IDLE;
               else if (r_end)       rx_st <= R_DATA;
            end
            R_DATA: begin
               if (samp_dec) begin
                  rdata[rbit] <= rmaj;
                  if (rmaj) rzero <= 1'b0;
               end
               if (r_end) begin
                  if (rbit == {1'b0, dbits} + 3'd4) rx_st <= par_en ? R_PAR : R_STOP;
                  else                              rbit  <= rbit + 3'd1;
               end
            end
            R_PAR: begin
               if (samp_dec) begin
                  rperr <= rmaj ^ (^rdata) ^ par_odd;
                  if (rmaj) rzero <= 1'b0;
               end
               if (r_end) rx_st <= R_STOP;
            end
            R_STOP: if (samp_dec) begin
               rx_push <= 1'b1;
               if (!rmaj && rzero) begin
                  rx_ent <= '{brk: 1'b1, ferr: 1'b1, perr: 1'b0, data: 8'd0};
                  rx_st  <= R_BRK;
               end else begin
                  rx_ent <= '{brk: 1'b0, ferr: ~rmaj, perr: rperr, data: rdata};
                  rx_st  <= R_IDLE;
               end
            end
            default: if (rx_s) rx_st <= R_IDLE;   // break: wait for line release
         endcase
      end
   end

`ifdef UART_FLOW_CTRL_EN
   localparam logic [RFB:0] RX_DEPTH_V = (RFB+1)'(RX_FIFO_DEPTH);
   logic cts_meta, cts_s;
   logic [RFB:0] rx_free;
   assign rx_free = RX_DEPTH_V - rx_lvl;
   assign cts_ok  = ~cts_s;

   // CTS synchroniser and registered RTS from RX free space
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cts_meta <= 1'b1; cts_s <= 1'b1; uart_rts_n <= 1'b1;
      end else begin
         cts_meta   <= uart_cts_n;
         cts_s      <= cts_meta;
         uart_rts_n <= (rx_free < (RFB+1)'(4));
      end
   end
`else
   assign cts_ok = 1'b1;
`endif

   // TX timing and pop decision; a pop on the last stop cycle gives back-to-back frames
   logic [15:0] tcnt;
   logic [2:0]  tbit;
   logic [7:0]  tsh, fmt_mask, tx_head_m;
   logic        tpar, tstopn, t_end, last_stop;
   assign t_end     = (tcnt == divisor);
   assign last_stop = (tx_st == T_STOP) && t_end && !tstopn;
   assign tx_pop    = ~tx_empty & cts_ok & ((tx_st == T_IDLE) | last_stop);
   assign fmt_mask  = 8'hFF >> (2'd3 - dbits);
   assign tx_head_m = tx_mem[tx_rp[TFB-1:0]] & fmt_mask;

   // TX frame FSM with registered serial output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_st   <= T_IDLE;
         tcnt    <= 16'd0;
         tbit    <= 3'd0;
         tsh     <= 8'd0;
         tpar    <= 1'b0;
         tstopn  <= 1'b0;
         uart_tx <= 1'b1;
      end else if (tx_pop) begin
         tx_st   <= T_START;
         tcnt    <= 16'd0;
         tsh     <= tx_head_m;
         tpar    <= ^tx_head_m;
         uart_tx <= 1'b0;
      end else begin
         if (tx_st != T_IDLE) tcnt <= t_end ? 16'd0 : tcnt + 16'd1;
         case (tx_st)
            T_START: if (t_end) begin
               tx_st   <= T_DATA;
               tbit    <= 3'd0;
               uart_tx <= tsh[0];
            end
            T_DATA: if (t_end) begin
               if (tbit == {1'b0, dbits} + 3'd4) begin
                  if (par_en) begin
                     tx_st   <= T_PAR;
                     uart_tx <= tpar ^ par_odd;
                  end else begin
                     tx_st   <= T_STOP;
                     tstopn  <= stop2;
                     uart_tx <= 1'b1;
                  end
               end else begin
                  tbit    <= tbit + 3'd1;
                  tsh     <= tsh >> 1;
                  uart_tx <= tsh[1];
               end
            end
            T_PAR: if (t_end) begin
               tx_st   <= T_STOP;
               tstopn  <= stop2;
               uart_tx <= 1'b1;
            end
            T_STOP: if (t_end) begin
               if (tstopn) tstopn <= 1'b0;
               else        tx_st  <= T_IDLE;
            end
            default: uart_tx <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Testbench for uart_fifo_controller: randomized frames checked against a
// reference model that builds expected serial waveforms and FIFO entries
// directly from the frame-format rules.
module tb_uart_fifo_controller;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        uart_rx, uart_tx, irq;
   logic [3:0]  apb_PADDR = 4'd0;
   logic        apb_PSEL = 1'b0, apb_PENABLE = 1'b0, apb_PWRITE = 1'b0;
   logic [31:0] apb_PWDATA = 32'd0;
   logic        apb_PREADY;
   logic [31:0] apb_PRDATA;
   logic        loop_en = 1'b0, rx_drv = 1'b1;

   int checks = 0;
   int errors = 0;

   localparam int L = 10;   // clk per bit at divisor 9

   logic trace [0:1023];
   logic exp_bits [$];

   assign uart_rx = loop_en ? uart_tx : rx_drv;
   always #5 clk = ~clk;

   uart_fifo_controller dut (
      .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq),
      .apb_PADDR(apb_PADDR), .apb_PSEL(apb_PSEL), .apb_PENABLE(apb_PENABLE),
      .apb_PWRITE(apb_PWRITE), .apb_PWDATA(apb_PWDATA), .apb_PREADY(apb_PREADY),
      .apb_PRDATA(apb_PRDATA)
`ifdef UART_FLOW_CTRL_EN
      , .uart_cts_n(1'b0), .uart_rts_n()
`endif
   );

   task automatic apb_xfer(input logic [3:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] r, output int waits);
      @(negedge clk);
      apb_PSEL = 1'b1; apb_PADDR = a; apb_PWRITE = w; apb_PWDATA = d; apb_PENABLE = 1'b0;
      @(negedge clk);
      apb_PENABLE = 1'b1;
      #1;
      waits = 0;
      while (!apb_PREADY && waits < 5000) begin
         @(negedge clk); #1; waits++;
      end
      r = apb_PRDATA;
      if (!apb_PREADY) begin
         checks++; errors++;
         $display("FAIL apb_timeout addr %h", a);
      end
      @(posedge clk); #1;
      apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
   endtask

   task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] r; int w;
      apb_xfer(a, 1'b1, d, r, w);
   endtask

   task automatic apb_rd(input logic [3:0] a, output logic [31:0] r);
      int w;
      apb_xfer(a, 1'b0, 32'd0, r, w);
   endtask

   function automatic logic [7:0] fmask(input int nd);
      return 8'((1 << nd) - 1);
   endfunction

   function automatic logic [31:0] conf_word(input int nd, input bit pe, odd, s2);
      return {11'd0, s2, odd, pe, 2'(nd - 5), 16'd9};
   endfunction

   task automatic drive_bit(input logic b);
      rx_drv = b;
      repeat (L) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nd, input bit pe, odd, s2, badp);
      logic p;
      @(negedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < nd; i++) drive_bit(d[i]);
      p = (^(d & fmask(nd))) ^ odd ^ badp;
      if (pe) drive_bit(p);
      drive_bit(1'b1);
      if (s2) drive_bit(1'b1);
      repeat (2) @(negedge clk);
   endtask

   // expected serial bits of one TX frame, one entry per bit period
   task automatic add_frame(input logic [7:0] d, input int nd, input bit pe, odd, s2);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < nd; i++) exp_bits.push_back(d[i]);
      if (pe) exp_bits.push_back((^(d & fmask(nd))) ^ odd);
      exp_bits.push_back(1'b1);
      if (s2) exp_bits.push_back(1'b1);
   endtask

   task automatic capture(input int n);
      int w = 0;
      @(negedge clk);
      while (uart_tx !== 1'b0 && w < 400) begin @(negedge clk); w++; end
      checks++;
      if (uart_tx !== 1'b0) begin errors++; $display("FAIL tx_start_timeout uart_tx %b", uart_tx); end
      for (int i = 0; i < n; i++) begin trace[i] = uart_tx; @(negedge clk); end
   endtask

   // every cycle of each expected bit period must match
   task automatic compare_trace(input string nm);
      for (int k = 0; k < exp_bits.size(); k++) begin
         int bad = 0;
         for (int c = 0; c < L; c++) if (trace[k*L + c] !== exp_bits[k]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s bit %0d got %0d wrong cycles exp level %b", nm, k, bad, exp_bits[k]);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", uart_tx); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      apb_rd(4'h0, r);
      checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL reset_rxdata got %h exp 80000000", r); end
      apb_rd(4'h4, r);
      checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL reset_status got %h exp 40000000", r); end
      apb_rd(4'h8, r);
      checks++; if (r !== 32'h0003_0009) begin errors++; $display("FAIL reset_conf got %h exp 00030009", r); end
      apb_rd(4'hC, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_irqreg got %h exp 0", r); end
   endtask

   task automatic test_tx_basic();
      logic [31:0] r;
      exp_bits.delete();
      add_frame(8'h55, 8, 0, 0, 0);
      exp_bits.push_back(1'b1);   // line idle afterwards
      fork
         apb_wr(4'h4, 32'h55);
         capture(exp_bits.size() * L);
      join
      compare_trace("tx_55");
      apb_rd(4'h4, r);
      checks++; if (r[30] !== 1'b1) begin errors++; $display("FAIL tx_empty_after got %b exp 1", r[30]); end
   endtask

   task automatic test_loopback_7e2();
      logic [31:0] r;
      apb_wr(4'h8, 32'h0016_0009);
      loop_en = 1'b1;
      exp_bits.delete();
      add_frame(8'h3A, 7, 1, 0, 1);
      exp_bits.push_back(1'b1);
      fork
         apb_wr(4'h4, 32'h3A);
         capture(exp_bits.size() * L);
      join
      compare_trace("tx_7e2");
      checks++; if (exp_bits.size() != 12) begin errors++; $display("FAIL frame_len got %0d exp 12", exp_bits.size()); end
      apb_rd(4'h0, r);
      checks++; if (r !== 32'h0000_003A) begin errors++; $display("FAIL loop_rx got %h exp 0000003a", r); end
      loop_en = 1'b0;
   endtask

   task automatic test_parity_err();
      logic [31:0] r;
      apb_wr(4'h8, conf_word(8, 1, 0, 0));
      send_frame(8'h41, 8, 1, 0, 0, 1);
      apb_rd(4'h0, r);
      checks++; if (r !== 32'h0000_0141) begin errors++; $display("FAIL perr_entry got %h exp 00000141", r); end
      apb_rd(4'h0, r);
      checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL perr_empty got %h exp 80000000", r); end
   endtask

   task automatic test_rx_random();
      logic [31:0] r, e;
      for (int n = 0; n < 10; n++) begin
         int nd = $urandom_range(5, 8);
         bit pe = 1'($urandom_range(0, 1));
         bit od = 1'($urandom_range(0, 1));
         bit s2 = 1'($urandom_range(0, 1));
         bit bp = pe && ($urandom_range(0, 3) == 0);
         logic [7:0] d = 8'($urandom_range(0, 255));
         if ((d & fmask(nd)) == 8'd0) d = 8'h01;   // keep away from break pattern
         apb_wr(4'h8, conf_word(nd, pe, od, s2));
         send_frame(d, nd, pe, od, s2, bp);
         e = {23'd0, bp, d & fmask(nd)};
         apb_rd(4'h0, r);
         checks++; if (r !== e) begin errors++; $display("FAIL rx_rand %0d got %h exp %h", n, r, e); end
      end
      apb_wr(4'h8, conf_word(8, 0, 0, 0));
   endtask

   task automatic test_tx_random();
      for (int n = 0; n < 3; n++) begin
         int nd = $urandom_range(5, 8);
         bit pe = 1'($urandom_range(0, 1));
         bit od = 1'($urandom_range(0, 1));
         bit s2 = 1'($urandom_range(0, 1));
         logic [7:0] d [3];
         apb_wr(4'h8, conf_word(nd, pe, od, s2));
         exp_bits.delete();
         for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom_range(0, 255));
            add_frame(d[i], nd, pe, od, s2);
         end
         exp_bits.push_back(1'b1);
         fork
            for (int i = 0; i < 3; i++) apb_wr(4'h4, {24'd0, d[i]});
            capture(exp_bits.size() * L);
         join
         compare_trace("tx_b2b");
      end
      apb_wr(4'h8, conf_word(8, 0, 0, 0));
   endtask

   task automatic test_break();
      logic [31:0] r;
      apb_wr(4'hC, 32'h0000_0008);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (12 * L) @(negedge clk);
      rx_drv = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL brk_irq got %b exp 1", irq); end
      apb_rd(4'h0, r);
      checks++; if (r !== 32'h0000_0600) begin errors++; $display("FAIL brk_entry got %h exp 00000600", r); end
      apb_rd(4'h0, r);
      checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL brk_single got %h exp 80000000", r); end
      apb_rd(4'hC, r);
      checks++; if (r[10] !== 1'b1) begin errors++; $display("FAIL brk_sticky got %b exp 1", r[10]); end
      apb_wr(4'hC, 32'h0000_0F00);
      repeat (2) @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL brk_irq_clr got %b exp 0", irq); end
   endtask

   task automatic test_txlow_irq();
      logic [31:0] r;
      apb_wr(4'hC, 32'h0000_0002);   // TXLOW, threshold 0, TX FIFO empty
      repeat (2) @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL txlow_irq got %b exp 1", irq); end
      apb_rd(4'hC, r);
      checks++; if (r !== 32'h0000_0002) begin errors++; $display("FAIL irqreg_rb got %h exp 00000002", r); end
      apb_wr(4'hC, 32'h0000_0000);
   endtask

   task automatic test_overrun();
      logic [31:0] r;
      logic [7:0] q [$];
      for (int n = 0; n < 65; n++) begin
         logic [7:0] d = 8'($urandom_range(1, 255));
         if (n < 64) q.push_back(d);
         send_frame(d, 8, 0, 0, 0, 0);
      end
      apb_rd(4'h4, r);
      checks++; if (r[15:8] !== 8'd64) begin errors++; $display("FAIL ovr_level got %0d exp 64", r[15:8]); end
      apb_rd(4'hC, r);
      checks++; if (r[8] !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", r[8]); end
      for (int n = 0; n < 64; n++) begin
         apb_rd(4'h0, r);
         checks++;
         if (r !== {24'd0, q[n]}) begin errors++; $display("FAIL ovr_data %0d got %h exp %h", n, r, q[n]); end
      end
      apb_rd(4'h0, r);
      checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL ovr_drained got %h exp 80000000", r); end
      apb_wr(4'hC, 32'h0000_0F00);
   endtask

   task automatic test_glitch_and_conf_stall();
      logic [31:0] r;
      int waits;
      @(negedge clk); rx_drv = 1'b0;
      @(negedge clk); rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      apb_rd(4'h4, r);
      checks++; if (r[15:8] !== 8'd0) begin errors++; $display("FAIL glitch_level got %0d exp 0", r[15:8]); end
      apb_wr(4'h4, 32'hA5);
      apb_xfer(4'h8, 1'b1, conf_word(8, 0, 0, 0), r, waits);
      checks++; if (waits < 80) begin errors++; $display("FAIL conf_stall got %0d waits exp >=80", waits); end
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL conf_tx_idle got %b exp 1", uart_tx); end
      apb_rd(4'h4, r);
      checks++; if (r[30] !== 1'b1) begin errors++; $display("FAIL conf_tx_empty got %b exp 1", r[30]); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_tx_basic();
      test_loopback_7e2();
      test_parity_err();
      test_rx_random();
      test_tx_random();
      test_break();
      test_txlow_irq();
      test_overrun();
      test_glitch_and_conf_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
